// File: rtl/ahb_mem_slave_if.sv
// rtl/ahb_mem_slave_if.sv - AHB-lite slave bus bundle with master/slave views
interface ahb_mem_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - AHB-lite memory slave with byte lanes, wait states and two-cycle ERROR
module ahb_mem_slave #(
  parameter int MEM_WORDS   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           rst,
  ahb_mem_slave_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t        state;
  logic [2:0]    wait_cnt;
  logic [AW-1:0] cap_idx;
  logic [3:0]    cap_lanes;
  logic          cap_write;

  logic [31:0]   mem [MEM_WORDS];

  logic          accept;
  logic          size_err;
  logic          addr_err;
  logic          completing;
  logic          wr_commit;
  logic [3:0]    lanes;
  logic [AW-1:0] idx;
  logic [31:0]   wr_merge;
  logic [31:0]   fwd_word;
  logic          unused_htrans0;

  assign unused_htrans0 = bus.HTRANS[0];

  // HREADYOUT is high exactly in IDLE, the completing DATA cycle and ERR2
  assign accept     = bus.HSEL && bus.HTRANS[1] && bus.HREADY && bus.HREADYOUT;
  assign idx        = bus.HADDR[AW+1:2];
  assign completing = (state == ST_DATA) && (wait_cnt == 3'd0);
  assign wr_commit  = completing && cap_write;

  always_comb begin
    lanes    = 4'b0000;
    size_err = 1'b0;
    case (bus.HSIZE)
      3'b000: lanes = 4'b0001 << bus.HADDR[1:0];
      3'b001: begin
        lanes    = bus.HADDR[1] ? 4'b1100 : 4'b0011;
        size_err = bus.HADDR[0];
      end
      3'b010: begin
        lanes    = 4'b1111;
        size_err = |bus.HADDR[1:0];
      end
      default: size_err = 1'b1;
    endcase
  end

  assign addr_err = (bus.HADDR[31:2] >= 30'(MEM_WORDS)) || size_err;

  // Word as it will look after this edge's write, so a pipelined read sees it
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      wr_merge[8*b +: 8] = cap_lanes[b] ? bus.HWDATA[8*b +: 8] : mem[cap_idx][8*b +: 8];
    end
  end

  assign fwd_word = (wr_commit && (cap_idx == idx)) ? wr_merge : mem[idx];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_commit && cap_lanes[b]) begin
        mem[cap_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= 3'd0;
      cap_idx       <= '0;
      cap_lanes     <= 4'b0000;
      cap_write     <= 1'b0;
      bus.HREADYOUT <= 1'b1;
      bus.HRESP     <= 1'b0;
      bus.HRDATA    <= 32'h0;
    end else if (accept) begin
      cap_idx   <= idx;
      cap_lanes <= lanes;
      cap_write <= bus.HWRITE && !addr_err;
      if (addr_err) begin
        state         <= ST_ERR1;
        wait_cnt      <= 3'd0;
        bus.HREADYOUT <= 1'b0;
        bus.HRESP     <= 1'b1;
      end else begin
        state         <= ST_DATA;
        wait_cnt      <= 3'(WAIT_STATES);
        bus.HREADYOUT <= (WAIT_STATES == 0);
        bus.HRESP     <= 1'b0;
        if ((WAIT_STATES == 0) && !bus.HWRITE) begin
          bus.HRDATA <= fwd_word;
        end
      end
    end else begin
      case (state)
        ST_DATA: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt      <= wait_cnt - 3'd1;
            bus.HREADYOUT <= (wait_cnt == 3'd1);
            if ((wait_cnt == 3'd1) && !cap_write) begin
              bus.HRDATA <= mem[cap_idx];
            end
          end else begin
            state         <= ST_IDLE;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= 1'b0;
          end
        end
        ST_ERR1: begin
          state         <= ST_ERR2;
          bus.HREADYOUT <= 1'b1;
          bus.HRESP     <= 1'b1;
        end
        default: begin
          state         <= ST_IDLE;
          bus.HREADYOUT <= 1'b1;
          bus.HRESP     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb/tb_ahb_mem_slave.sv - vectors plus random traffic for three wait-state builds of ahb_mem_slave
module tb_ahb_mem_slave;
  typedef struct {
    int          tgt;
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          gap;
    bit          has_exp;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int          m_tgt = 0;
  logic        m_hsel = 1'b0;
  logic [31:0] m_haddr = '0;
  logic [1:0]  m_htrans = 2'b00;
  logic        m_hwrite = 1'b0;
  logic [2:0]  m_hsize = 3'b010;
  logic [31:0] m_hwdata = '0;
  logic        s_ready, s_resp;
  logic [31:0] s_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [3][64];
  logic [3:0]  ref_ok  [3][64];
  xfer_t       pend[$];
  xfer_t       tbl[$];

  ahb_mem_slave_if bus0 ();
  ahb_mem_slave_if bus2 ();
  ahb_mem_slave_if bus3 ();

  assign bus0.HSEL = m_hsel && (m_tgt == 0);
  assign bus2.HSEL = m_hsel && (m_tgt == 1);
  assign bus3.HSEL = m_hsel && (m_tgt == 2);
  assign {bus0.HADDR, bus0.HTRANS, bus0.HWRITE, bus0.HSIZE, bus0.HWDATA} =
         {m_haddr, m_htrans, m_hwrite, m_hsize, m_hwdata};
  assign {bus2.HADDR, bus2.HTRANS, bus2.HWRITE, bus2.HSIZE, bus2.HWDATA} =
         {m_haddr, m_htrans, m_hwrite, m_hsize, m_hwdata};
  assign {bus3.HADDR, bus3.HTRANS, bus3.HWRITE, bus3.HSIZE, bus3.HWDATA} =
         {m_haddr, m_htrans, m_hwrite, m_hsize, m_hwdata};
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;
  assign bus3.HREADY = bus3.HREADYOUT;

  ahb_mem_slave #(.MEM_WORDS(64), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst), .bus(bus0));
  ahb_mem_slave #(.MEM_WORDS(64), .WAIT_STATES(2)) u_ws2 (.clk(clk), .rst(rst), .bus(bus2));
  ahb_mem_slave #(.MEM_WORDS(64), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst), .bus(bus3));

  always_comb begin
    case (m_tgt)
      1:       {s_ready, s_resp, s_rdata} = {bus2.HREADYOUT, bus2.HRESP, bus2.HRDATA};
      2:       {s_ready, s_resp, s_rdata} = {bus3.HREADYOUT, bus3.HRESP, bus3.HRDATA};
      default: {s_ready, s_resp, s_rdata} = {bus0.HREADYOUT, bus0.HRESP, bus0.HRDATA};
    endcase
  end

  function automatic int ws_of(input int tgt);
    return (tgt == 0) ? 0 : (tgt == 1) ? 2 : 3;
  endfunction

  function automatic bit is_err(input xfer_t t);
    return (t.addr / 4 >= 64) || (t.size > 2) ||
           (t.size == 1 && t.addr % 2 != 0) || (t.size == 2 && t.addr % 4 != 0);
  endfunction

  function automatic bit in_lane(input xfer_t t, input int b);
    int off = int'(t.addr % 4);
    return (t.size == 0 && b == off) || (t.size == 1 && b / 2 == off / 2) || (t.size == 2);
  endfunction

  function automatic xfer_t mk(input int tgt, input logic [31:0] addr, input bit wr,
                               input logic [2:0] size, input logic [31:0] wdata, input int gap,
                               input bit exp_err, input logic [31:0] exp_rdata);
    xfer_t t;
    t.tgt = tgt; t.addr = addr; t.wr = wr; t.size = size; t.wdata = wdata; t.gap = gap;
    t.has_exp = 1'b1; t.exp_err = exp_err; t.exp_rdata = exp_rdata;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tgt=%0d t=%0t: got %h expected %h", name, m_tgt, $time, act, exp);
    end
  endtask

  task automatic drive_idle();
    int r = $urandom_range(0, 2);
    m_hsel   = (r != 2);
    m_htrans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
    m_haddr  = $urandom_range(0, 255);
    m_hwrite = 1'($urandom);
    m_hsize  = 3'($urandom_range(0, 2));
  endtask

  // Cycle-level master: presents pend in order, checks each cycle against the reference
  task automatic run_queue(input int tgt);
    xfer_t dp;
    bit    dp_on = 0, dp_err = 0, ready_exp, resp_exp, present;
    int    dp_cyc = 0, guard = 0, ws, w;
    m_tgt = tgt;
    ws = ws_of(tgt);
    while ((pend.size() > 0 || dp_on) && guard < 5000) begin
      guard++;
      if (dp_on) begin
        ready_exp = dp_err ? (dp_cyc == 1) : (dp_cyc == ws);
        resp_exp  = dp_err;
      end else begin
        ready_exp = 1'b1;
        resp_exp  = 1'b0;
      end
      chk("hreadyout", 32'(s_ready), 32'(ready_exp));
      chk("hresp", 32'(s_resp), 32'(resp_exp));
      if (dp_on && dp.has_exp && dp_cyc == 0) chk("vector_err", 32'(s_resp), 32'(dp.exp_err));
      if (dp_on && ready_exp && !dp_err) begin
        w = int'(dp.addr / 4);
        if (dp.wr) begin
          for (int b = 0; b < 4; b++) begin
            if (in_lane(dp, b)) begin
              ref_mem[tgt][w][8*b +: 8] = dp.wdata[8*b +: 8];
              ref_ok[tgt][w][b] = 1'b1;
            end
          end
        end else begin
          if (ref_ok[tgt][w] == 4'hF) chk("hrdata_model", s_rdata, ref_mem[tgt][w]);
          if (dp.has_exp) chk("hrdata_vector", s_rdata, dp.exp_rdata);
        end
      end
      m_hwdata = (dp_on && dp.wr) ? dp.wdata : $urandom;
      present = 1'b0;
      if (pend.size() > 0) begin
        if (pend[0].gap > 0) pend[0].gap--;
        else present = 1'b1;
      end
      if (present) begin
        m_hsel   = 1'b1;
        m_htrans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        m_haddr  = pend[0].addr;
        m_hwrite = pend[0].wr;
        m_hsize  = pend[0].size;
      end else begin
        drive_idle();
      end
      if (dp_on && ready_exp) dp_on = 1'b0;
      else if (dp_on) dp_cyc++;
      if (present && ready_exp) begin
        dp     = pend.pop_front();
        dp_on  = 1'b1;
        dp_cyc = 0;
        dp_err = is_err(dp);
      end
      @(posedge clk); #1;
    end
    if (guard >= 5000) begin
      checks++; errors++;
      $display("FAIL engine_timeout tgt=%0d: got %0d cycles expected fewer", tgt, guard);
      pend.delete();
    end
    drive_idle();
  endtask

  task automatic gen_random(input int tgt, input int n);
    xfer_t t;
    for (int i = 0; i < n; i++) begin
      t.tgt = tgt; t.has_exp = 1'b0; t.exp_err = 1'b0; t.exp_rdata = '0;
      t.wr    = 1'($urandom);
      t.wdata = $urandom;
      t.gap   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      t.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      t.addr  = ($urandom_range(0, 9) == 0) ? $urandom_range(256, 400) : $urandom_range(0, 63);
      if ($urandom_range(0, 4) != 0) begin
        if (t.size == 1) t.addr[0] = 1'b0;
        if (t.size == 2) t.addr[1:0] = 2'b00;
      end
      pend.push_back(t);
    end
  endtask

  initial begin
    for (int t = 0; t < 3; t++) for (int w = 0; w < 64; w++) ref_ok[t][w] = 4'h0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready0", 32'(bus0.HREADYOUT), 32'd1);
    chk("reset_resp0", 32'(bus0.HRESP), 32'd0);
    chk("reset_rdata0", bus0.HRDATA, 32'h0);
    chk("reset_ready3", 32'(bus3.HREADYOUT), 32'd1);
    chk("reset_rdata3", bus3.HRDATA, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    tbl.push_back(mk(0, 32'h10, 1, 3'd2, 32'hDEADBEEF, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h10, 0, 3'd2, 32'h0,        0, 0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 32'h10, 1, 3'd2, 32'h00000000, 2, 0, 32'h0));
    tbl.push_back(mk(0, 32'h11, 1, 3'd0, 32'h5555AA55, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h10, 0, 3'd2, 32'h0,        1, 0, 32'h0000AA00));
    tbl.push_back(mk(0, 32'h12, 1, 3'd1, 32'hBEEF1234, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h10, 0, 3'd2, 32'h0,        0, 0, 32'hBEEFAA00));
    tbl.push_back(mk(0, 32'h00, 1, 3'd2, 32'h0BADF00D, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h100, 0, 3'd2, 32'h0,       0, 1, 32'h0));
    tbl.push_back(mk(0, 32'h02, 1, 3'd2, 32'hFFFFFFFF, 0, 1, 32'h0));
    tbl.push_back(mk(0, 32'h13, 1, 3'd1, 32'hFFFFFFFF, 0, 1, 32'h0));
    tbl.push_back(mk(0, 32'h00, 1, 3'd3, 32'hFFFFFFFF, 0, 1, 32'h0));
    tbl.push_back(mk(0, 32'h00, 0, 3'd2, 32'h0,        0, 0, 32'h0BADF00D));
    tbl.push_back(mk(0, 32'h20, 1, 3'd2, 32'h12345678, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h20, 0, 3'd2, 32'h0,        0, 0, 32'h12345678));
    tbl.push_back(mk(1, 32'h04, 1, 3'd2, 32'hCAFEF00D, 0, 0, 32'h0));
    tbl.push_back(mk(1, 32'h04, 0, 3'd2, 32'h0,        0, 0, 32'hCAFEF00D));
    tbl.push_back(mk(1, 32'h07, 1, 3'd0, 32'h11000000, 0, 0, 32'h0));
    tbl.push_back(mk(1, 32'h04, 0, 3'd2, 32'h0,        0, 0, 32'h11FEF00D));
    tbl.push_back(mk(1, 32'h104, 1, 3'd2, 32'h0,       0, 1, 32'h0));
    tbl.push_back(mk(2, 32'h30, 1, 3'd2, 32'h0F0F1234, 0, 0, 32'h0));
    tbl.push_back(mk(2, 32'h30, 0, 3'd2, 32'h0,        0, 0, 32'h0F0F1234));
    for (int i = 0; i < tbl.size(); i++) begin
      pend.push_back(tbl[i]);
      if (i == tbl.size() - 1 || tbl[i+1].tgt != tbl[i].tgt) run_queue(tbl[i].tgt);
    end

    // Reset in the middle of a stalled write must drop the write
    m_tgt = 2;
    m_hsel = 1'b1; m_htrans = 2'b10; m_haddr = 32'h30; m_hwrite = 1'b1; m_hsize = 3'd2;
    @(posedge clk); #1;
    chk("rst_seq_stall", 32'(bus3.HREADYOUT), 32'd0);
    drive_idle();
    m_hwdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(bus3.HREADYOUT), 32'd1);
    chk("rst_mid_resp", 32'(bus3.HRESP), 32'd0);
    chk("rst_mid_rdata", bus3.HRDATA, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    pend.push_back(mk(2, 32'h30, 0, 3'd2, 32'h0, 0, 0, 32'h0F0F1234));
    run_queue(2);

    for (int t = 0; t < 3; t++) begin
      gen_random(t, 150);
      run_queue(t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 Parameter MEM_WORDS, default 64, is the number of 32-bit words in the internal memory (power of two, 4..1024).
REQ-002 Parameter WAIT_STATES, default 0, is the number of extra low-HREADYOUT cycles inserted in every OKAY data phase (0..7).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 HSEL  input  1  slave select.
REQ-006 HADDR  input  32  byte address, address phase.
REQ-007 HTRANS  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 HWRITE  input  1  1 = write, 0 = read, address phase.
REQ-009 HSIZE  input  3  000 byte, 001 halfword, 010 word; other values are an error.
REQ-010 HWDATA  input  32  write data, data phase.
REQ-011 HREADY  input  1  bus-level ready (the previous transfer's data phase completes this cycle).
REQ-012 HRDATA  output  32  read data, valid when HREADYOUT=1 in a read data phase.
REQ-013 HREADYOUT  output  1  this slave's data-phase completion.
REQ-014 HRESP  output  1  0 OKAY, 1 ERROR.

Function
REQ-015 A transfer SHALL be accepted on a rising edge where HSEL=1, HTRANS[1]=1 and HREADY=1; HADDR, HWRITE and HSIZE are captured at that edge.
REQ-016 IDLE/BUSY, HSEL=0 or HREADY=0 SHALL accept nothing and SHALL yield HREADYOUT=1, HRESP=0 in the following cycle.
REQ-017 FSM states: IDLE, DATA, ERR1, ERR2; a valid accept enters DATA, an erroneous accept enters ERR1.
REQ-018 An accept is erroneous when HADDR[31:2] >= MEM_WORDS, HSIZE > 010, halfword with HADDR[0]=1, or word with HADDR[1:0]!=00.
REQ-019 DATA: a wait counter loads WAIT_STATES at accept; HREADYOUT=0 while the counter is nonzero (decrement per cycle), then HREADYOUT=1, HRESP=0 for exactly one cycle.
REQ-020 With WAIT_STATES=0 the data phase SHALL complete in the cycle immediately after the address phase (1 cycle latency).
REQ-021 Write: on the completing edge (HREADYOUT=1), only the byte lanes selected by HSIZE and captured HADDR[1:0] are written from the same lanes of HWDATA; other bytes are unchanged.
REQ-022 Read: HRDATA SHALL present the full addressed 32-bit word (all lanes) while HREADYOUT=1; HRDATA is don't-care while HREADYOUT=0 and SHALL hold its last value otherwise.
REQ-023 ERR1: HREADYOUT=0, HRESP=1; ERR2 (next cycle): HREADYOUT=1, HRESP=1; no memory update for an erroneous transfer.
REQ-024 A new transfer presented in the completing cycle of DATA or in ERR2 SHALL be accepted (pipelined); zero-wait back-to-back transfers sustain one per cycle.
REQ-025 Back-to-back write then read of the same word SHALL return the newly written data.
REQ-026 HTRANS changing to IDLE during a wait or error phase SHALL not abort the current data phase.
REQ-027 Memory contents are not reset; reading an unwritten word returns an undefined value.

Reset
REQ-028 While rst=0: FSM=IDLE, wait counter=0, captured controls cleared, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-029 Reset asserted mid-transfer SHALL abandon it with no memory write; the first edge after release may accept a new transfer.

Verification
REQ-030 WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF, HREADYOUT=1 each data phase, HRESP=0.
REQ-031 Byte write 0xAA to 0x11 over word 0x00000000 at 0x10, then word read 0x10 -> 0x0000AA00.
REQ-032 WAIT_STATES=2: read -> HREADYOUT sequence 0,0,1 over the data phase; data valid in third cycle.
REQ-033 Read 0x100 (MEM_WORDS=64) -> ERR1 (HREADYOUT=0,HRESP=1), ERR2 (1,1); word write at 0x02 -> same ERROR, memory unchanged.
REQ-034 Zero-wait NONSEQ write 0x12345678 to 0x20 followed next cycle by read 0x20 -> read returns 0x12345678, no stall cycles.
REQ-035 rst pulsed low during a WAIT_STATES=3 write -> outputs at reset values immediately, target word unchanged after release.
